reg_writeback_unit: RTL and testbench
=====================================

# reg_writeback_unit

Writer-side companion to the core's 32×32 register file. Accepts completed results from the ALU path and from the load path, buffers loads in a small FIFO, and arbitrates onto the register file's single write port through a registered output stage. It also keeps a per-register scoreboard of outstanding loads, so decode can stall, and optionally forwards the value currently being written.

## Interface
Parameters:
- LD_DEPTH, 4: load FIFO entries; power of two, ≥2.
- XLEN, 32: data width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-high.
- alu_valid  in  1  ALU result present this cycle; always accepted.
- alu_rd  in  5  destination register.
- alu_data  in  XLEN  result.
- ld_valid  in  1  load result offered.
- ld_ready  out  1  FIFO can accept; equals !full.
- ld_rd  in  5  load destination.
- ld_data  in  XLEN  load data.
- iss_valid  in  1  a load is issuing; mark iss_rd pending.
- iss_rd  in  5  issuing load destination.
- rs1, rs2  in  5 each  decode source queries.
- rs1_busy, rs2_busy  out  1 each  source has an outstanding load (combinational).
- rs1_fwd_valid, rs2_fwd_valid  out  1 each  write port currently writing this source.
- rs1_fwd_data, rs2_fwd_data  out  XLEN each  forwarded value.
- wb_a3  out  5  register file A3.
- wb_we3  out  1  register file WE3.
- wb_wd3  out  XLEN  register file WD3.

## Operation
- Load handshake: a push occurs when ld_valid and ld_ready are both high. Pushes with ld_rd == 0 complete the handshake but are discarded.
- ALU results with alu_rd == 0 are discarded.
- Arbitration each cycle, for loading the output register:
  - alu_valid with rd ≠ 0: take the ALU result.
  - Otherwise, FIFO non-empty: pop the head.
  - Otherwise: wb_we3 = 0 next cycle.
- The ALU path has strict priority. Loads may wait indefinitely under back-to-back ALU traffic.
- FIFO: circular buffer with wrap-around pointers and an occupancy count in 0..LD_DEPTH.
  - Push and pop in the same cycle are legal when full: ld_ready stays 0 that cycle, so no push occurs.
  - Push and pop in the same cycle when empty: no bypass; the entry must be stored first.
- Scoreboard: 32 pending bits; bit 0 is never set.
  - iss_valid sets pending[iss_rd].
  - A load retiring through the output register clears pending[rd] when that load is loaded into the output register.
  - Set and clear of the same bit in the same cycle: set wins.
  - An ALU write never touches the scoreboard.
- rsN_busy = pending[rsN].
- rsN_fwd_valid = wb_we3 && wb_a3 == rsN && rsN ≠ 0. The data is wb_wd3.

## Timing
- Reset values:
  - wb_we3 = 0, wb_a3 = 0, wb_wd3 = 0.
  - ld_ready = 0 during reset, 1 in the first cycle after reset.
  - FIFO empty; all pending bits 0.
  - fwd/busy outputs 0.
- Reset mid-operation drops every buffered load and all pending bits.
- ALU latency: result on cycle N gives wb_we3 = 1 on cycle N+1. The register file commits at the end of N+1.
- Load latency: minimum 2 cycles (push at N, pop at N+1, write at N+2), plus one cycle per intervening ALU result.
- ld_ready is registered-state derived (from the count only), with no combinational path from ld_valid.

## Configuration
- WB_FWD_EN:
  - Defined: forwarding outputs behave as above.
  - Undefined: rsN_fwd_valid = 0 and rsN_fwd_data = 0. rsN_busy additionally asserts when wb_we3 && wb_a3 == rsN && rsN ≠ 0, so decode stalls one cycle instead of forwarding.

## Structure
- Shared package rv_pkg:
  - XLEN.
  - REG_AW = 5.
  - wb_entry_t = {rd[4:0], data[XLEN-1:0]}.
  - Constant REG_ZERO = 5'd0.
- Sub-module wb_fifo, parameterised by LD_DEPTH and entry type.
  - Ports: clk, rst, push, push_data, pop, head, full, empty.
- Arbitration, the output register and the scoreboard stay in reg_writeback_unit.

## Test plan
- ALU only: after reset, alu_valid with rd = 5 and data = 0x0000000A at cycle N -> wb_we3 = 1, wb_a3 = 5, wb_wd3 = 0x0A at N+1; wb_we3 = 0 at N+2.
- Load scoreboard:
  - Issue load to rd = 9 -> rs1 = 9 gives rs1_busy = 1.
  - Push ld_rd = 9, data 0x20 -> write at +2 cycles.
  - rs1_busy drops when the write appears.
- Priority and full:
  - Push 4 loads (rd 6, 7, 8, 12) while alu_valid is held high -> ld_ready = 0 after the 4th push.
  - Writes show ALU values only.
  - Release ALU -> loads retire in order 6, 7, 8, 12.
- x0 handling: alu_rd = 0 and a load push with ld_rd = 0 -> no wb_we3 pulse, FIFO count unchanged; iss_rd = 0 -> rs1 = 0 busy stays 0.
- Set/clear collision: load to rd = 13 retires in the same cycle iss_valid marks rd = 13 -> rs2 = 13 busy remains 1.
- Reset mid-run plus forwarding:
  - With 3 loads buffered, assert rst -> outputs zero, all busy 0, ld_ready = 0 then 1, and no stale writes afterwards.
  - With WB_FWD_EN: rs1 equal to wb_a3 during a write -> rs1_fwd_valid = 1 with matching data.
  - Without WB_FWD_EN: rs1_busy = 1 instead.

Source files
------------

// File: rtl/rv_pkg.sv
// rv_pkg: shared core types for the register writeback path (XLEN, register address width, writeback entry)
package rv_pkg;
   localparam int XLEN = 32;
   localparam int REG_AW = 5;
   localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: circular load-result buffer with wrap-around pointers and occupancy count; no push-to-pop bypass
module wb_fifo
   import rv_pkg::*;
#(
   parameter int  LD_DEPTH = 4,
   parameter type T        = wb_entry_t
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  T     push_data,
   input  logic pop,
   output T     head,
   output logic full,
   output logic empty
);
   localparam int AW = $clog2(LD_DEPTH);
   T               r_mem [LD_DEPTH];
   logic [AW-1:0]  r_wp;
   logic [AW-1:0]  r_rp;
   logic [AW:0]    r_cnt;
   logic           w_push;
   logic           w_pop;
   assign full   = r_cnt == (AW+1)'(LD_DEPTH);
   assign empty  = r_cnt == '0;
   assign head   = r_mem[r_rp];
   assign w_push = push && !full;
   assign w_pop  = pop && !empty;
   // pointer/count update; storage is written only on accepted pushes and never reset
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wp] <= push_data;
            r_wp        <= r_wp + 1'b1;
         end
         if (w_pop) r_rp <= r_rp + 1'b1;
         r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
   end
endmodule

// File: rtl/reg_writeback_unit.sv
// reg_writeback_unit: ALU/load arbitration onto the regfile write port, load scoreboard, optional forwarding (WB_FWD_EN)
module reg_writeback_unit
   import rv_pkg::*;
#(
   parameter int LD_DEPTH = 4,
   parameter int XLEN     = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            alu_valid,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN-1:0] alu_data,
   input  logic            ld_valid,
   output logic            ld_ready,
   input  logic [4:0]      ld_rd,
   input  logic [XLEN-1:0] ld_data,
   input  logic            iss_valid,
   input  logic [4:0]      iss_rd,
   input  logic [4:0]      rs1,
   input  logic [4:0]      rs2,
   output logic            rs1_busy,
   output logic            rs2_busy,
   output logic            rs1_fwd_valid,
   output logic            rs2_fwd_valid,
   output logic [XLEN-1:0] rs1_fwd_data,
   output logic [XLEN-1:0] rs2_fwd_data,
   output logic [4:0]      wb_a3,
   output logic            wb_we3,
   output logic [XLEN-1:0] wb_wd3
);
   logic            r_we3;
   logic [4:0]      r_a3;
   logic [XLEN-1:0] r_wd3;
   logic [31:0]     r_pend;
   logic [31:0]     w_pend_nxt;
   logic            w_alu_take;
   logic            w_push;
   logic            w_pop;
   logic            w_full;
   logic            w_empty;
   logic            w_hit1;
   logic            w_hit2;
   wb_entry_t       w_head;
   wb_entry_t       w_push_entry;
   assign w_alu_take   = alu_valid && alu_rd != REG_ZERO;
   assign w_pop        = !w_alu_take && !w_empty;
   assign ld_ready     = !rst && !w_full;
   assign w_push       = ld_valid && ld_ready && ld_rd != REG_ZERO;
   assign w_push_entry = '{rd: ld_rd, data: ld_data};
   wb_fifo #(.LD_DEPTH(LD_DEPTH), .T(wb_entry_t)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (w_push),
      .push_data (w_push_entry),
      .pop       (w_pop),
      .head      (w_head),
      .full      (w_full),
      .empty     (w_empty)
   );
   // output register: ALU result has strict priority over the buffered load head
   always_ff @(posedge clk) begin
      if (rst) begin
         r_we3 <= 1'b0;
         r_a3  <= REG_ZERO;
         r_wd3 <= '0;
      end else begin
         r_we3 <= w_alu_take || w_pop;
         if (w_alu_take) begin
            r_a3  <= alu_rd;
            r_wd3 <= alu_data;
         end else if (w_pop) begin
            r_a3  <= w_head.rd;
            r_wd3 <= w_head.data;
         end
      end
   end
   // pending-load bits: a retiring load clears its bit, an issue sets it (set wins), x0 never pending
   always_comb begin
      w_pend_nxt = r_pend & ~(w_pop ? (32'b1 << w_head.rd) : 32'b0);
      w_pend_nxt = (w_pend_nxt | (iss_valid ? (32'b1 << iss_rd) : 32'b0)) & ~32'b1;
   end
   // scoreboard register
   always_ff @(posedge clk) begin
      if (rst) r_pend <= '0;
      else     r_pend <= w_pend_nxt;
   end
   assign wb_we3 = r_we3;
   assign wb_a3  = r_a3;
   assign wb_wd3 = r_wd3;
   assign w_hit1 = r_we3 && r_a3 == rs1 && rs1 != REG_ZERO;
   assign w_hit2 = r_we3 && r_a3 == rs2 && rs2 != REG_ZERO;
`ifdef WB_FWD_EN
   assign rs1_busy      = r_pend[rs1];
   assign rs2_busy      = r_pend[rs2];
   assign rs1_fwd_valid = w_hit1;
   assign rs2_fwd_valid = w_hit2;
   assign rs1_fwd_data  = r_wd3;
   assign rs2_fwd_data  = r_wd3;
`else
   assign rs1_busy      = r_pend[rs1] || w_hit1;
   assign rs2_busy      = r_pend[rs2] || w_hit2;
   assign rs1_fwd_valid = 1'b0;
   assign rs2_fwd_valid = 1'b0;
   assign rs1_fwd_data  = '0;
   assign rs2_fwd_data  = '0;
`endif
endmodule

// File: tb/tb_reg_writeback_unit.sv
// tb_reg_writeback_unit: directed scenarios with literal expectations plus a random run against a queue-based model
module tb_reg_writeback_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        alu_valid = 1'b0, ld_valid = 1'b0, iss_valid = 1'b0;
   logic [4:0]  alu_rd = '0, ld_rd = '0, iss_rd = '0, rs1 = '0, rs2 = '0;
   logic [31:0] alu_data = '0, ld_data = '0;
   logic        ld_ready, rs1_busy, rs2_busy, rs1_fwd_valid, rs2_fwd_valid, wb_we3;
   logic [31:0] rs1_fwd_data, rs2_fwd_data, wb_wd3;
   logic [4:0]  wb_a3;
   int          n_chk = 0;
   int          n_fail = 0;
`ifdef WB_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif
   reg_writeback_unit dut (
      .clk(clk), .rst(rst), .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2),
      .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rs1_fwd_valid(rs1_fwd_valid), .rs2_fwd_valid(rs2_fwd_valid),
      .rs1_fwd_data(rs1_fwd_data), .rs2_fwd_data(rs2_fwd_data), .wb_a3(wb_a3), .wb_we3(wb_we3), .wb_wd3(wb_wd3)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   // reference model: queue of buffered loads, pending bit array, expected write port contents
   typedef struct { logic [4:0] rd; logic [31:0] d; } ent_t;
   ent_t        q[$];
   ent_t        e;
   bit [31:0]   pend;
   bit          m_we, m_ok, room;
   logic [4:0]  m_a3;
   logic [31:0] m_wd;
   always @(posedge clk) begin
      if (rst) begin
         q.delete();
         pend = '0;
         m_we = 0; m_a3 = '0; m_wd = '0; m_ok = 1;
      end else begin
         room = q.size() < 4;
         if (alu_valid && alu_rd != 0) begin
            m_we = 1; m_a3 = alu_rd; m_wd = alu_data;
         end else if (q.size() > 0) begin
            e = q.pop_front();
            m_we = 1; m_a3 = e.rd; m_wd = e.d;
            pend[e.rd] = 0;
         end else m_we = 0;
         if (ld_valid && room && ld_rd != 0) q.push_back('{ld_rd, ld_data});
         if (iss_valid && iss_rd != 0) pend[iss_rd] = 1;
      end
   end
   function automatic bit hit(input logic [4:0] rs);
      return m_we && m_a3 == rs && rs != 0;
   endfunction
   // every-cycle comparison of all outputs against the model
   always @(negedge clk) begin
      if (m_ok) begin
         chk("m_ld_ready", ld_ready, (!rst && q.size() < 4));
         chk("m_we3", wb_we3, m_we);
         if (m_we) begin
            chk("m_a3", wb_a3, m_a3);
            chk("m_wd3", wb_wd3, m_wd);
         end
         chk("m_rs1_busy", rs1_busy, pend[rs1] || (!FWD && hit(rs1)));
         chk("m_rs2_busy", rs2_busy, pend[rs2] || (!FWD && hit(rs2)));
         chk("m_rs1_fv", rs1_fwd_valid, FWD && hit(rs1));
         chk("m_rs2_fv", rs2_fwd_valid, FWD && hit(rs2));
         if (!FWD) chk("m_rs1_fd0", rs1_fwd_data, 0);
         if (!FWD) chk("m_rs2_fd0", rs2_fwd_data, 0);
         if (FWD && hit(rs1)) chk("m_rs1_fd", rs1_fwd_data, m_wd);
         if (FWD && hit(rs2)) chk("m_rs2_fd", rs2_fwd_data, m_wd);
      end
   end
   logic [4:0] rds [4] = '{5'd6, 5'd7, 5'd8, 5'd12};
   initial begin
      tick(); tick();
      chk("rst_we", wb_we3, 0); chk("rst_a3", wb_a3, 0); chk("rst_wd", wb_wd3, 0);
      chk("rst_ready", ld_ready, 0);
      rst = 0; #1;
      chk("post_rst_ready", ld_ready, 1);
      // ALU only
      alu_valid = 1; alu_rd = 5; alu_data = 32'h0000000A;
      tick(); alu_valid = 0; #1;
      chk("alu_we", wb_we3, 1); chk("alu_a3", wb_a3, 5); chk("alu_wd", wb_wd3, 32'hA);
      tick();
      chk("alu_we_off", wb_we3, 0);
      // load scoreboard
      iss_valid = 1; iss_rd = 9; rs1 = 9;
      tick(); iss_valid = 0; ld_valid = 1; ld_rd = 9; ld_data = 32'h20; #1;
      chk("ld_busy", rs1_busy, 1);
      tick(); ld_valid = 0; #1;
      chk("ld_busy2", rs1_busy, 1); chk("ld_we0", wb_we3, 0);
      tick();
      chk("ld_we", wb_we3, 1); chk("ld_a3", wb_a3, 9); chk("ld_wd", wb_wd3, 32'h20);
      chk("ld_busy_wr", rs1_busy, !FWD);
      chk("ld_fv", rs1_fwd_valid, FWD);
      if (FWD) chk("ld_fd", rs1_fwd_data, 32'h20);
      tick();
      chk("ld_busy_done", rs1_busy, 0);
      // priority and full
      for (int i = 0; i < 4; i++) begin
         alu_valid = 1; alu_rd = 20; alu_data = 100 + i;
         ld_valid = 1; ld_rd = rds[i]; ld_data = 32'h40 + i;
         tick();
      end
      ld_valid = 0; alu_data = 104; #1;
      chk("full_ready", ld_ready, 0); chk("pri_a3", wb_a3, 20); chk("pri_wd", wb_wd3, 103);
      tick(); alu_valid = 0; #1;
      chk("pri_wd2", wb_wd3, 104); chk("full_ready2", ld_ready, 0);
      for (int j = 0; j < 4; j++) begin
         tick();
         chk("order_we", wb_we3, 1); chk("order_a3", wb_a3, rds[j]); chk("order_wd", wb_wd3, 32'h40 + j);
      end
      tick();
      chk("drain_we", wb_we3, 0);
      // x0 handling
      alu_valid = 1; alu_rd = 0; ld_valid = 1; ld_rd = 0; iss_valid = 1; iss_rd = 0; rs1 = 0;
      tick(); alu_valid = 0; ld_valid = 0; iss_valid = 0; #1;
      chk("x0_we", wb_we3, 0); chk("x0_busy", rs1_busy, 0);
      tick();
      chk("x0_we2", wb_we3, 0); chk("x0_ready", ld_ready, 1);
      // set/clear collision on rd 13
      iss_valid = 1; iss_rd = 13; rs2 = 13;
      tick(); iss_valid = 0; ld_valid = 1; ld_rd = 13; ld_data = 32'h55;
      tick(); ld_valid = 0; iss_valid = 1; iss_rd = 13;
      tick(); iss_valid = 0; #1;
      chk("col_a3", wb_a3, 13); chk("col_busy", rs2_busy, 1);
      tick();
      chk("col_busy2", rs2_busy, 1);
      // reset with three buffered loads
      for (int i = 0; i < 3; i++) begin
         alu_valid = 1; alu_rd = 21; alu_data = i;
         ld_valid = 1; ld_rd = 5'(i + 1); ld_data = 32'h90 + i;
         iss_valid = 1; iss_rd = 5'(i + 1);
         tick();
      end
      rs1 = 1; rs2 = 2;
      rst = 1; alu_valid = 0; ld_valid = 0; iss_valid = 0;
      tick();
      chk("mr_we", wb_we3, 0); chk("mr_a3", wb_a3, 0); chk("mr_wd", wb_wd3, 0);
      chk("mr_ready", ld_ready, 0); chk("mr_b1", rs1_busy, 0); chk("mr_b2", rs2_busy, 0);
      tick(); rst = 0; #1;
      chk("mr_ready1", ld_ready, 1);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("mr_stale", wb_we3, 0);
      end
      // forwarding vs stall on ALU write
      alu_valid = 1; alu_rd = 17; alu_data = 32'h77;
      tick(); alu_valid = 0; rs1 = 17; #1;
      chk("fw_valid", rs1_fwd_valid, FWD); chk("fw_busy", rs1_busy, !FWD);
      if (FWD) chk("fw_data", rs1_fwd_data, 32'h77);
      // random traffic, checked every cycle by the model
      for (int c = 0; c < 3000; c++) begin
         tick();
         rst       = $urandom_range(0, 299) == 0;
         alu_valid = $urandom_range(0, 99) < 45;
         alu_rd    = 5'($urandom);  alu_data = $urandom;
         ld_valid  = $urandom_range(0, 99) < 60;
         ld_rd     = 5'($urandom);  ld_data = $urandom;
         iss_valid = $urandom_range(0, 99) < 30;
         iss_rd    = 5'($urandom);
         rs1       = 5'($urandom);  rs2 = 5'($urandom);
      end
      tick(); tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
